// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants used by the
// buffered transmitter and the matching receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; head is shown
// combinationally on dout. Pushes while full and pops while empty are ignored.
module uart_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == (AW+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign dout   = r_mem[r_rd_ptr];
   assign count  = r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a FIFO, LSB-first
// serialiser with registered line output. Optional parity bit: UART_PARITY_EN.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2,
   parameter int DEPTH        = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     tx_out,
   output logic                     tx_busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BCW = $clog2(DATA_BITS);

   uart_state_t          r_state, w_state_nxt;
   logic [BW-1:0]        r_baud, w_baud_nxt;
   logic [BCW-1:0]       r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 r_tx, w_tx_nxt;
   logic                 r_parity;
   logic                 w_baud_end;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [7:0]           w_head;

   uart_byte_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (w_pop),
      .din   (in_data),
      .dout  (w_head),
      .count (fifo_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign in_ready   = !w_full;
   assign tx_out     = r_tx;
   assign tx_busy    = (r_state != ST_IDLE);
   assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_baud_nxt  = '0;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = ST_DATA;
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
         ST_DATA: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_shift_nxt = r_shift >> 1;
               if (r_bit == BCW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_bit_nxt = r_bit + BCW'(1);
               end
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (w_baud_end) begin
               w_baud_nxt  = '0;
               w_state_nxt = ST_STOP;
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
`endif
         ST_STOP: begin
            if (w_baud_end) begin
               w_baud_nxt = '0;
               // Back-to-back frames: next start bit follows the stop bit directly.
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_head;
                  w_state_nxt = ST_START;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_baud_nxt = r_baud + BW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Line level is derived from the next state so tx_out comes straight from a flop.
   always_comb begin
      w_tx_nxt = IDLE_LEVEL;
      case (w_state_nxt)
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = w_shift_nxt[0];
         ST_PARITY: w_tx_nxt = r_parity;
         default:   w_tx_nxt = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_tx    <= IDLE_LEVEL;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk) begin
      if (w_pop) r_parity <= (^w_head) ^ (PARITY_ODD != 0);
   end
`else
   logic w_unused_parity_odd;
   assign r_parity            = 1'b0;
   assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

endmodule
